// File: rtl/mult_pkg.sv
// Shared encodings for the Booth multiplier: accumulate-op codes, Booth digit
// selects and the triplet decoder.
package mult_pkg;

   typedef enum logic [1:0] {
      ACC_MUL  = 2'b00,
      ACC_MADD = 2'b01,
      ACC_MSUB = 2'b10
   } acc_op_e;

   typedef enum logic [2:0] {
      BD_ZERO,
      BD_POS1,
      BD_POS2,
      BD_NEG1,
      BD_NEG2
   } booth_sel_e;

   function automatic booth_sel_e booth_decode(input logic [2:0] trip);
      booth_sel_e sel;
      case (trip)
         3'b001, 3'b010: sel = BD_POS1;
         3'b011:         sel = BD_POS2;
         3'b100:         sel = BD_NEG2;
         3'b101, 3'b110: sel = BD_NEG1;
         default:        sel = BD_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: selects 0/+-A/+-2A from a triplet and
// places it at column 2*IDX; negation is ~X here plus neg_o added at that column.
module booth_pp_gen
   import mult_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int IDX   = 0
) (
   input  logic [2:0]         triplet_i,
   input  logic [WIDTH+1:0]   a_ext_i,
   output logic [2*WIDTH-1:0] pp_o,
   output logic               neg_o
);

   localparam int XW = WIDTH + 3;
   localparam int OW = 2 * WIDTH;
   localparam int SH = 2 * IDX;

   booth_sel_e    sel;
   logic [XW-1:0] a1;
   logic [XW-1:0] a2;
   logic [XW-1:0] mag;

   assign a1 = {a_ext_i[WIDTH+1], a_ext_i};
   assign a2 = {a_ext_i, 1'b0};

   // NOTE: every signal written in this block gets a default first, so no latch can form.
   always_comb begin
      sel   = booth_decode(triplet_i);
      mag   = '0;
      neg_o = 1'b0;
      case (sel)
         BD_POS1: mag = a1;
         BD_POS2: mag = a2;
         BD_NEG1: begin mag = ~a1; neg_o = 1'b1; end
         BD_NEG2: begin mag = ~a2; neg_o = 1'b1; end
         default: mag = '0;
      endcase
      pp_o = {{(OW-XW){mag[XW-1]}}, mag} << SH;
   end

endmodule

// File: rtl/booth_mult_pipe.sv
// Pipelined radix-4 Booth / carry-save multiplier with MUL, MADD and MSUB
// against a 2W-bit accumulator; latency of 2 or 3 cycles.
module booth_mult_pipe
   import mult_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               mult_en,
   input  logic [WIDTH-1:0]   mult_A,
   input  logic [WIDTH-1:0]   mult_B,
   input  logic               is_unsign,
   input  logic [1:0]         acc_op,
   input  logic [2*WIDTH-1:0] acc_in,
   output logic               mult_busy,
   output logic               mult_valid,
   output logic [2*WIDTH-1:0] mult_out
);

   localparam int PW   = 2 * WIDTH;
   localparam int NPP  = (WIDTH + 2) / 2;
   localparam int NOPS = NPP + 1;

   if (STAGES != 2 && STAGES != 3) begin : g_bad_stages
      $error("booth_mult_pipe: STAGES must be 2 or 3");
   end
   if (WIDTH < 8 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("booth_mult_pipe: WIDTH must be even and >= 8");
   end

   function automatic logic [PW-1:0] acc_apply(input logic [1:0]    op,
                                               input logic [PW-1:0] acc,
                                               input logic [PW-1:0] prod);
      case (op)
         ACC_MADD: return acc + prod;
         ACC_MSUB: return acc - prod;
         default:  return prod;
      endcase
   endfunction

   // Sign or zero extension to W+2 bits makes one signed datapath exact for both modes.
   logic [WIDTH+1:0] a_ext;
   logic [WIDTH+2:0] b_pad;
   assign a_ext = {{2{~is_unsign & mult_A[WIDTH-1]}}, mult_A};
   assign b_pad = {{2{~is_unsign & mult_B[WIDTH-1]}}, mult_B, 1'b0};

   logic [PW-1:0]  ops [NOPS];
   logic [NPP-1:0] pp_neg;
   logic [PW-1:0]  neg_vec;

   for (genvar i = 0; i < NPP; i++) begin : g_pp
      booth_pp_gen #(.WIDTH(WIDTH), .IDX(i)) u_pp (
         .triplet_i (b_pad[2*i+2:2*i]),
         .a_ext_i   (a_ext),
         .pp_o      (ops[i]),
         .neg_o     (pp_neg[i])
      );
   end

   always_comb begin
      neg_vec = '0;
      for (int i = 0; i < NPP; i++) neg_vec[2*i] = pp_neg[i];
   end
   assign ops[NPP] = neg_vec;

   // Linear array of 3:2 compressors folds all operands into sum/carry.
   logic [PW-1:0] csa_s [NOPS-1];
   logic [PW-1:0] csa_c [NOPS-1];
   assign csa_s[0] = ops[0];
   assign csa_c[0] = ops[1];
   for (genvar k = 1; k < NOPS - 1; k++) begin : g_csa
      assign csa_s[k] = csa_s[k-1] ^ csa_c[k-1] ^ ops[k+1];
      assign csa_c[k] = ((csa_s[k-1] & csa_c[k-1]) |
                         (csa_s[k-1] & ops[k+1])   |
                         (csa_c[k-1] & ops[k+1])) << 1;
   end

   logic [PW-1:0] s1_sum_d, s1_carry_d;
   logic [PW-1:0] s1_sum_q, s1_carry_q, s1_acc_q;
   logic [1:0]    s1_op_q;
   logic          s1_vld_q;
   logic          mult_valid_q;
   logic [PW-1:0] mult_out_q;

   assign s1_sum_d   = csa_s[NOPS-2];
   assign s1_carry_d = csa_c[NOPS-2];

   always_ff @(posedge clk) begin
      if (rst) s1_vld_q <= 1'b0;
      else     s1_vld_q <= mult_en & ~flush;
      // NOTE: datapath registers have no reset; the valid bits alone qualify them.
      if (mult_en) begin
         s1_sum_q   <= s1_sum_d;
         s1_carry_q <= s1_carry_d;
         s1_acc_q   <= acc_in;
         s1_op_q    <= acc_op;
      end
   end

   if (STAGES == 3) begin : g_three
      logic [PW-1:0] s2_prod_q, s2_acc_q;
      logic [1:0]    s2_op_q;
      logic          s2_vld_q;

      always_ff @(posedge clk) begin
         if (rst) s2_vld_q <= 1'b0;
         else     s2_vld_q <= s1_vld_q & ~flush;
         if (s1_vld_q) begin
            s2_prod_q <= s1_sum_q + s1_carry_q;
            s2_acc_q  <= s1_acc_q;
            s2_op_q   <= s1_op_q;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            mult_valid_q <= 1'b0;
            mult_out_q   <= '0;
         end else begin
            mult_valid_q <= s2_vld_q & ~flush;
            if (s2_vld_q & ~flush) mult_out_q <= acc_apply(s2_op_q, s2_acc_q, s2_prod_q);
         end
      end

      assign mult_busy = s1_vld_q | s2_vld_q;
   end else begin : g_two
      logic [PW-1:0] fin_d;
      assign fin_d = acc_apply(s1_op_q, s1_acc_q, s1_sum_q + s1_carry_q);

      always_ff @(posedge clk) begin
         if (rst) begin
            mult_valid_q <= 1'b0;
            mult_out_q   <= '0;
         end else begin
            mult_valid_q <= s1_vld_q & ~flush;
            if (s1_vld_q & ~flush) mult_out_q <= fin_d;
         end
      end

      assign mult_busy = s1_vld_q;
   end

   assign mult_valid = mult_valid_q;
   assign mult_out   = mult_out_q;

endmodule

// File: tb/tb_booth_mult_pipe.sv
// Scoreboard bench: drives STAGES=2 and STAGES=3 instances with the same
// stimulus and checks each against an arithmetic reference model.
module tb_booth_mult_pipe;

   localparam int W = 32;

   typedef struct packed {
      logic [63:0] val;
      logic [31:0] due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, flush, mult_en, is_unsign;
   logic [31:0] mult_A, mult_B;
   logic [1:0]  acc_op;
   logic [63:0] acc_in;

   logic        busy  [2];
   logic        valid [2];
   logic [63:0] out   [2];

   booth_mult_pipe #(.WIDTH(W), .STAGES(2)) u_dut2 (
      .clk(clk), .rst(rst), .flush(flush), .mult_en(mult_en),
      .mult_A(mult_A), .mult_B(mult_B), .is_unsign(is_unsign),
      .acc_op(acc_op), .acc_in(acc_in),
      .mult_busy(busy[0]), .mult_valid(valid[0]), .mult_out(out[0])
   );

   booth_mult_pipe #(.WIDTH(W), .STAGES(3)) u_dut3 (
      .clk(clk), .rst(rst), .flush(flush), .mult_en(mult_en),
      .mult_A(mult_A), .mult_B(mult_B), .is_unsign(is_unsign),
      .acc_op(acc_op), .acc_in(acc_in),
      .mult_busy(busy[1]), .mult_valid(valid[1]), .mult_out(out[1])
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_tests  = 0;
   int          n_fail   = 0;
   exp_t        sb [2][$];
   logic [63:0] hold [2];
   int          rst_edge = -1;
   bit          mon_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Reference: exact 2W-bit product from plain arithmetic, then accumulate mod 2^64.
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic uns, input logic [1:0] op,
                                         input logic [63:0] acc);
      logic [63:0] p;
      if (uns) p = {32'd0, a} * {32'd0, b};
      else     p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      case (op)
         2'b01:   return acc + p;
         2'b10:   return acc - p;
         default: return p;
      endcase
   endfunction

   // Applies one cycle of inputs and updates the scoreboards for the coming edge.
   task automatic drive(input logic en, input logic [31:0] a, input logic [31:0] b,
                        input logic uns, input logic [1:0] op, input logic [63:0] acc,
                        input logic fl, input logic rs, input logic use_exp,
                        input logic [63:0] exp_v);
      int   edge_n;
      exp_t e;
      @(negedge clk);
      mult_en   = en;
      mult_A    = a;
      mult_B    = b;
      is_unsign = uns;
      acc_op    = op;
      acc_in    = acc;
      flush     = fl;
      rst       = rs;
      edge_n    = cyc + 1;
      for (int d = 0; d < 2; d++) begin
         if (rs) begin
            sb[d].delete();
         end else begin
            if (fl)
               while (sb[d].size() > 0 && int'(sb[d][$].due) >= edge_n) void'(sb[d].pop_back());
            if (en && !fl) begin
               e.val = use_exp ? exp_v : model(a, b, uns, op, acc);
               e.due = 32'(edge_n + d + 1);
               sb[d].push_back(e);
            end
         end
      end
      if (rs) rst_edge = edge_n;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 2'b00, '0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic op(input logic [31:0] a, input logic [31:0] b, input logic uns,
                     input logic [1:0] ao, input logic [63:0] acc, input logic [63:0] ev);
      drive(1'b1, a, b, uns, ao, acc, 1'b0, 1'b0, 1'b1, ev);
   endtask

   initial begin : monitor
      exp_t  e;
      string tag;
      wait (mon_en);
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            tag = $sformatf("S%0d", d + 2);
            if (cyc == rst_edge) begin
               check({tag, " rst valid"}, 64'(valid[d]), 64'd0);
               check({tag, " rst out"},   out[d],        64'd0);
               check({tag, " rst busy"},  64'(busy[d]),  64'd0);
               hold[d] = '0;
            end else begin
               if (valid[d] === 1'b1) begin
                  if (sb[d].size() == 0) begin
                     check({tag, " unexpected valid"}, 64'd1, 64'd0);
                  end else begin
                     e = sb[d].pop_front();
                     check({tag, " result"},  out[d],      e.val);
                     check({tag, " latency"}, 64'(cyc),   64'(e.due));
                     hold[d] = e.val;
                  end
               end else begin
                  check({tag, " valid"}, 64'(valid[d]), 64'd0);
                  check({tag, " hold"},  out[d],        hold[d]);
                  if (sb[d].size() > 0 && int'(sb[d][0].due) <= cyc) begin
                     e = sb[d].pop_front();
                     check({tag, " missing valid"}, 64'd0, 64'd1);
                  end
               end
               check({tag, " busy"}, 64'(busy[d]), 64'(sb[d].size() != 0));
            end
         end
      end
   end

   initial begin : stimulus
      logic [31:0] corners [5];
      logic [31:0] a, b;
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'h7FFF_FFFF;
      corners[3] = 32'h8000_0000;
      corners[4] = 32'hFFFF_FFFF;

      rst = 1'b1; flush = 1'b0; mult_en = 1'b0; is_unsign = 1'b0;
      mult_A = '0; mult_B = '0; acc_op = '0; acc_in = '0;
      hold[0] = '0; hold[1] = '0;

      drive(1'b0, '0, '0, 1'b0, 2'b00, '0, 1'b0, 1'b1, 1'b0, '0);
      drive(1'b0, '0, '0, 1'b0, 2'b00, '0, 1'b0, 1'b1, 1'b0, '0);
      mon_en = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 2'b00, '0, 1'b0, 1'b1, 1'b0, '0);
      idle(2);

      op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 2'b00, '0, 64'h3FFF_FFFF_0000_0001);
      idle(4);
      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2'b00, '0, 64'hFFFF_FFFE_0000_0001);
      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00, '0, 64'h0000_0000_0000_0001);
      idle(4);

      // Four back-to-back issues.
      op(32'h8000_0000, 32'h8000_0000, 1'b0, 2'b00, '0, 64'h4000_0000_0000_0000);
      op(32'd1, 32'd1, 1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
      op(32'd3, 32'd7, 1'b0, 2'b10, 64'h10, 64'hFFFF_FFFF_FFFF_FFFB);
      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2'b11, 64'h1234, 64'hFFFF_FFFE_0000_0001);
      idle(5);

      // Flush one cycle after issue, then flush together with an issue.
      op(32'd5, 32'd6, 1'b0, 2'b00, '0, 64'd30);
      drive(1'b0, '0, '0, 1'b0, 2'b00, '0, 1'b1, 1'b0, 1'b0, '0);
      idle(4);
      drive(1'b1, 32'd9, 32'd9, 1'b0, 2'b00, '0, 1'b1, 1'b0, 1'b1, 64'd81);
      idle(4);

      // Reset with ops in flight.
      op(32'd11, 32'd13, 1'b0, 2'b00, '0, 64'd143);
      op(32'd17, 32'd19, 1'b1, 2'b00, '0, 64'd323);
      drive(1'b0, '0, '0, 1'b0, 2'b00, '0, 1'b0, 1'b1, 1'b0, '0);
      idle(4);
      op(32'hFFFF_FFFE, 32'd3, 1'b0, 2'b00, '0, 64'hFFFF_FFFF_FFFF_FFFA);
      idle(4);

      for (int i = 0; i < 10000; i++) begin
         a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
         drive($urandom_range(0, 9) < 8, a, b, 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), {$urandom, $urandom},
               $urandom_range(0, 19) == 0, $urandom_range(0, 249) == 0, 1'b0, '0);
      end
      idle(8);

      check("S2 drained", 64'(sb[0].size()), 64'd0);
      check("S3 drained", 64'(sb[1].size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
